// File: rtl/btn_cond_pkg.sv
// -----------------------------------------------------------------------------
// btn_cond_pkg
// Shared types and helpers for the push-button conditioner.
//   btn_state_t   : conditioner FSM states
//   ms_to_cycles  : converts a millisecond interval to clock cycles
//   max3_u        : largest of three unsigned values (used for counter sizing)
// -----------------------------------------------------------------------------
package btn_cond_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DB    = 3'd1,
    HELD_DELAY  = 3'd2,
    HELD_REPEAT = 3'd3,
    RELEASE_DB  = 3'd4
  } btn_state_t;

  // Whole-millisecond cycle count; the frequency is divided first so large
  // clock rates do not overflow 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned ms);
    return (freq_hz / 32'd1000) * ms;
  endfunction

  function automatic int unsigned max3_u(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//   clk   in  destination clock
//   reset in  asynchronous, active-high reset (both stages load RESET_VAL)
//   d     in  asynchronous input level
//   q     out synchronized level (second stage)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage shift register; the first stage may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns one raw, bouncy push-button level into clean single-cycle events:
// press, release and auto-repeat. All outputs are registered.
//   clk           in  system clock
//   reset         in  asynchronous, active-high reset
//   btn_in        in  raw button level, active high, asynchronous to clk
//   repeat_en     in  auto-repeat enable, sampled every cycle
//   btn_level     out debounced button level
//   press_pulse   out one-cycle pulse on an accepted press
//   release_pulse out one-cycle pulse on an accepted release
//   repeat_pulse  out one-cycle pulse per auto-repeat tick
//   step_pulse    out press_pulse | repeat_pulse, same cycle as its source
// -----------------------------------------------------------------------------
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 32'd50_000_000,
  parameter int unsigned DEBOUNCE_MS     = 32'd20,
  parameter int unsigned REPEAT_DELAY_MS = 32'd500,
  parameter int unsigned REPEAT_RATE_MS  = 32'd100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int unsigned DB_CYC   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned DLY_CYC  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
  localparam int unsigned RATE_CYC = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);
  localparam int unsigned MAX_CYC  = max3_u(DB_CYC, DLY_CYC, RATE_CYC);
  localparam int          CNT_W    = $clog2(MAX_CYC + 32'd1);

  // Targets carry one extra bit so the incremented count can be compared
  // without wrapping, even when a target equals 1.
  localparam logic [CNT_W:0]   DB_TGT   = DB_CYC[CNT_W:0];
  localparam logic [CNT_W:0]   DLY_TGT  = DLY_CYC[CNT_W:0];
  localparam logic [CNT_W:0]   RATE_TGT = RATE_CYC[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((DB_CYC < 32'd1) || (DLY_CYC < 32'd1) || (RATE_CYC < 32'd1)) begin : g_bad_timing
    $error("button_conditioner: every derived cycle count must be >= 1");
  end

  logic             sync_s;
  btn_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic             repeating_r, repeating_nxt_s;
  logic             btn_level_r, btn_level_nxt_s;
  logic             press_r, press_nxt_s;
  logic             release_r, release_nxt_s;
  logic             repeat_r, repeat_nxt_s;
  logic             step_r, step_nxt_s;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync_s)
  );

  // The stable-sample count including the current cycle; each interval
  // fires when this reaches its target.
  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // State, counter, flag and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      repeating_r <= 1'b0;
      btn_level_r <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      repeat_r    <= 1'b0;
      step_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      repeating_r <= repeating_nxt_s;
      btn_level_r <= btn_level_nxt_s;
      press_r     <= press_nxt_s;
      release_r   <= release_nxt_s;
      repeat_r    <= repeat_nxt_s;
      step_r      <= step_nxt_s;
    end
  end

  // Next-state and next-output logic. repeat_en only masks the pulse; the
  // counter cadence is identical either way.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    repeating_nxt_s = repeating_r;
    btn_level_nxt_s = btn_level_r;
    press_nxt_s     = 1'b0;
    release_nxt_s   = 1'b0;
    repeat_nxt_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (sync_s) begin
          state_nxt_s = PRESS_DB;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end

      PRESS_DB: begin
        if (!sync_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_inc_s >= DB_TGT) begin
          press_nxt_s     = 1'b1;
          btn_level_nxt_s = 1'b1;
          cnt_nxt_s       = CNT_ZERO;
          state_nxt_s     = HELD_DELAY;
        end else begin
          cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
      end

      HELD_DELAY: begin
        if (!sync_s) begin
          state_nxt_s     = RELEASE_DB;
          cnt_nxt_s       = CNT_ONE;
          repeating_nxt_s = 1'b0;
        end else if (cnt_inc_s >= DLY_TGT) begin
          repeat_nxt_s    = repeat_en;
          cnt_nxt_s       = CNT_ZERO;
          repeating_nxt_s = 1'b1;
          state_nxt_s     = HELD_REPEAT;
        end else begin
          cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
      end

      HELD_REPEAT: begin
        if (!sync_s) begin
          state_nxt_s = RELEASE_DB;
          cnt_nxt_s   = CNT_ONE;
        end else if (cnt_inc_s >= RATE_TGT) begin
          repeat_nxt_s = repeat_en;
          cnt_nxt_s    = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
      end

      RELEASE_DB: begin
        if (sync_s) begin
          // Bounce back high: resume holding and restart the current interval.
          state_nxt_s = repeating_r ? HELD_REPEAT : HELD_DELAY;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_inc_s >= DB_TGT) begin
          release_nxt_s   = 1'b1;
          btn_level_nxt_s = 1'b0;
          repeating_nxt_s = 1'b0;
          cnt_nxt_s       = CNT_ZERO;
          state_nxt_s     = IDLE;
        end else begin
          cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
      end

      default: begin
        state_nxt_s     = IDLE;
        cnt_nxt_s       = CNT_ZERO;
        repeating_nxt_s = 1'b0;
        btn_level_nxt_s = 1'b0;
      end
    endcase

    step_nxt_s = press_nxt_s | repeat_nxt_s;
  end

  assign btn_level     = btn_level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;
  assign step_pulse    = step_r;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with DB=20, DLY=100, RATE=30 cycles.
// Edge n of a run is the n-th clock edge sampling the driven pattern; outputs
// observed on the following falling edge are attributed to edge n.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btn_in;
  logic repeat_en;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic step_pulse;

  int n_checks;
  int n_fail;

  bit btn_pat [0:511];
  bit rep_pat [0:511];

  int press_q[$];
  int release_q[$];
  int repeat_q[$];
  int step_q[$];
  int multi_hot;
  int step_err;
  int lvl_rise;
  int lvl_fall;

  button_conditioner #(
    .CLK_FREQ_HZ     (32'd1000),
    .DEBOUNCE_MS     (32'd20),
    .REPEAT_DELAY_MS (32'd100),
    .REPEAT_RATE_MS  (32'd30)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .repeat_en     (repeat_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .step_pulse    (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clear_pat(input bit rep_val);
    for (int i = 0; i < 512; i++) begin
      btn_pat[i] = 1'b0;
      rep_pat[i] = rep_val;
    end
  endtask

  task automatic set_btn(input int lo, input int hi, input bit v);
    for (int i = lo; i <= hi; i++) btn_pat[i] = v;
  endtask

  task automatic set_rep(input int lo, input int hi, input bit v);
    for (int i = lo; i <= hi; i++) rep_pat[i] = v;
  endtask

  // Drive the pattern for n edges (called at a falling edge) and log events.
  task automatic run_pattern(input int n);
    press_q.delete();
    release_q.delete();
    repeat_q.delete();
    step_q.delete();
    multi_hot = 0;
    step_err  = 0;
    lvl_rise  = -1;
    lvl_fall  = -1;
    for (int i = 0; i < n; i++) begin
      btn_in    = btn_pat[i];
      repeat_en = rep_pat[i];
      @(posedge clk);
      @(negedge clk);
      if (press_pulse)   press_q.push_back(i);
      if (release_pulse) release_q.push_back(i);
      if (repeat_pulse)  repeat_q.push_back(i);
      if (step_pulse)    step_q.push_back(i);
      if ((int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse)) > 1) multi_hot++;
      if (step_pulse !== (press_pulse | repeat_pulse)) step_err++;
      if (btn_level && (lvl_rise < 0)) lvl_rise = i;
      if (!btn_level && (lvl_rise >= 0) && (lvl_fall < 0)) lvl_fall = i;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset_outputs",
                int'({btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: clean press, 80-cycle hold, no repeat
    clear_pat(1'b0);
    set_btn(0, 79, 1'b1);
    run_pattern(140);
    check_value("t1_press_cnt",   press_q.size(), 1);
    check_value("t1_press_edge",  q_at(press_q, 0), 21);
    check_value("t1_level_rise",  lvl_rise, 21);
    check_value("t1_release_cnt", release_q.size(), 1);
    check_value("t1_release_edge", q_at(release_q, 0), 101);
    check_value("t1_level_fall",  lvl_fall, 101);
    check_value("t1_repeat_cnt",  repeat_q.size(), 0);
    check_value("t1_step_cnt",    step_q.size(), 1);

    // 2: bounce every 5 cycles for 40 cycles, then steady high from edge 40
    clear_pat(1'b0);
    for (int i = 0; i < 40; i++) btn_pat[i] = (((i / 5) % 2) == 0);
    set_btn(40, 99, 1'b1);
    run_pattern(150);
    check_value("t2_press_cnt",    press_q.size(), 1);
    check_value("t2_press_edge",   q_at(press_q, 0), 61);
    check_value("t2_level_rise",   lvl_rise, 61);
    check_value("t2_release_edge", q_at(release_q, 0), 121);

    // 3: isolated 10-cycle glitches
    clear_pat(1'b0);
    set_btn(10, 19, 1'b1);
    set_btn(40, 49, 1'b1);
    set_btn(70, 79, 1'b1);
    run_pattern(120);
    check_value("t3_events",
                press_q.size() + release_q.size() + repeat_q.size() + step_q.size(), 0);
    check_value("t3_level_rise", lvl_rise, -1);

    // 4: auto-repeat over a 200-edge hold
    clear_pat(1'b1);
    set_btn(0, 199, 1'b1);
    run_pattern(260);
    check_value("t4_step_cnt",     step_q.size(), 4);
    check_value("t4_step0",        q_at(step_q, 0), 21);
    check_value("t4_step1",        q_at(step_q, 1), 121);
    check_value("t4_step2",        q_at(step_q, 2), 151);
    check_value("t4_step3",        q_at(step_q, 3), 181);
    check_value("t4_repeat_cnt",   repeat_q.size(), 3);
    check_value("t4_release_edge", q_at(release_q, 0), 221);
    check_value("t4_multi_hot",    multi_hot, 0);
    check_value("t4_step_or",      step_err, 0);

    // 4b: repeat_en dropped around edge 121 masks that tick only
    clear_pat(1'b1);
    set_btn(0, 199, 1'b1);
    set_rep(110, 130, 1'b0);
    run_pattern(260);
    check_value("t4b_step_cnt", step_q.size(), 3);
    check_value("t4b_step1",    q_at(step_q, 1), 151);
    check_value("t4b_step2",    q_at(step_q, 2), 181);

    // 5: release bounce while repeating; HELD_REPEAT re-entered at edge 172
    clear_pat(1'b1);
    set_btn(0, 159, 1'b1);
    set_btn(170, 249, 1'b1);
    run_pattern(320);
    check_value("t5_step_cnt",     step_q.size(), 5);
    check_value("t5_step3",        q_at(step_q, 3), 202);
    check_value("t5_step4",        q_at(step_q, 4), 232);
    check_value("t5_release_cnt",  release_q.size(), 1);
    check_value("t5_release_edge", q_at(release_q, 0), 271);
    check_value("t5_level_fall",   lvl_fall, 271);
    check_value("t5_multi_hot",    multi_hot, 0);

    // 6: reset during HELD_REPEAT, button still held afterwards
    clear_pat(1'b1);
    set_btn(0, 121, 1'b1);
    run_pattern(122);
    check_value("t6_pre_step",  int'(step_pulse), 1);
    check_value("t6_pre_level", int'(btn_level), 1);
    #2;
    reset = 1'b1;
    #1;
    check_value("t6_async_clear",
                int'({btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse}), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_pat(1'b1);
    set_btn(0, 59, 1'b1);
    run_pattern(110);
    check_value("t6_press_cnt",    press_q.size(), 1);
    check_value("t6_press_edge",   q_at(press_q, 0), 21);
    check_value("t6_release_edge", q_at(release_q, 0), 81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
